// File: rtl/joint_servo.sv
// Button-driven servo joint: position stepper FSM plus a framed PWM generator.
// Define JOINT_SERVO_LIMIT_EN to clamp the position to [POS_MIN, POS_MAX] instead of [0x00, 0xFF].
module joint_servo #(
    parameter int          STEP_DIV   = 50000,
    parameter int          PWM_PERIOD = 1000000,
    parameter int          PWM_MIN    = 50000,
    parameter int          PWM_SCALE  = 196,
    parameter logic [7:0]  POS_INIT   = 8'h80
`ifdef JOINT_SERVO_LIMIT_EN
    ,
    parameter logic [7:0]  POS_MIN    = 8'h20,
    parameter logic [7:0]  POS_MAX    = 8'hE0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    output logic [7:0] pos,
    output logic       pwm,
    output logic       moving
);

    // state | meaning
    // IDLE  | holding position, waiting for up/down
    // MOVE  | stepping pos once every STEP_DIV cycles in dir_up_q
    typedef enum logic {IDLE, MOVE} state_t;

`ifdef JOINT_SERVO_LIMIT_EN
    localparam logic [7:0] LIM_LO = POS_MIN;
    localparam logic [7:0] LIM_HI = POS_MAX;
`else
    localparam logic [7:0] LIM_LO = 8'h00;
    localparam logic [7:0] LIM_HI = 8'hFF;
`endif

    localparam int          SW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
    // The sampling edge that enters MOVE already counts as the first step cycle.
    localparam logic [SW-1:0] ENTRY_CNT = SW'((STEP_DIV == 1) ? 0 : 1);
    localparam logic [19:0] FRAME_LAST = 20'(PWM_PERIOD - 1);
    localparam logic [19:0] WIDTH_RST  = 20'(PWM_MIN + int'(POS_INIT) * PWM_SCALE);

    state_t        state_q;
    logic          dir_up_q;
    logic [SW-1:0] step_q;
    logic [7:0]    pos_q;
    logic          moving_q;
    logic [19:0]   frame_q;
    logic [19:0]   width_q;
    logic [19:0]   width_d;
    logic          pwm_q;

    logic cmd_up, cmd_dn, cmd_hold;
    assign cmd_up   = (btn == 2'b01);
    assign cmd_dn   = (btn == 2'b10);
    assign cmd_hold = !(cmd_up || cmd_dn);

    function automatic logic [7:0] nudge(input logic [7:0] p, input logic up);
        if (up)
            return (p >= LIM_HI) ? LIM_HI : p + 8'd1;
        else
            return (p <= LIM_LO) ? LIM_LO : p - 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dir_up_q <= 1'b0;
            step_q   <= '0;
            pos_q    <= POS_INIT;
            moving_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cmd_hold) begin
                        state_q  <= MOVE;
                        moving_q <= 1'b1;
                        dir_up_q <= cmd_up;
                        step_q   <= ENTRY_CNT;
                        if (STEP_DIV == 1)
                            pos_q <= nudge(pos_q, cmd_up);
                    end
                end
                MOVE: begin
                    if (cmd_hold) begin
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                        step_q   <= '0;
                    end else if (cmd_up != dir_up_q) begin
                        dir_up_q <= cmd_up;
                        step_q   <= '0;
                    end else if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        pos_q  <= nudge(pos_q, dir_up_q);
                    end else begin
                        step_q <= step_q + SW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    moving_q <= 1'b0;
                    step_q   <= '0;
                end
            endcase
        end
    end

    assign width_d = 20'(PWM_MIN) + 20'(pos_q) * 20'(PWM_SCALE);

    // Width is only sampled at the frame boundary so a pulse is never cut or stretched mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            width_q <= WIDTH_RST;
            pwm_q   <= 1'b0;
        end else begin
            pwm_q <= (frame_q < width_q);
            if (frame_q == FRAME_LAST) begin
                frame_q <= '0;
                width_q <= width_d;
            end else begin
                frame_q <= frame_q + 20'd1;
            end
        end
    end

    assign pos    = pos_q;
    assign pwm    = pwm_q;
    assign moving = moving_q;

endmodule

// File: tb/tb_joint_servo.sv
// Scoreboard bench for joint_servo: expectations are queued per edge number and checked at the negedge.
module tb_joint_servo;

    localparam int PERIOD = 1000;
`ifdef JOINT_SERVO_LIMIT_EN
    localparam int HI = 8'hE0;
    localparam int LO = 8'h20;
`else
    localparam int HI = 8'hFF;
    localparam int LO = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [7:0] pos;
    logic       pwm;
    logic       moving;

    joint_servo #(
        .STEP_DIV(4), .PWM_PERIOD(PERIOD), .PWM_MIN(100), .PWM_SCALE(2), .POS_INIT(8'h80)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn), .pos(pos), .pwm(pwm), .moving(moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   hi_acc = 0;
    int   frame_hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    // sig: 0 = pos, 1 = moving, 2 = pwm, 3 = pwm high count of the frame ending at this edge
    task automatic expect_at(input int at, input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        int   i;
        e.at = at; e.sig = sig; e.val = val; e.tag = tag;
        i = 0;
        while (i < exp_q.size() && exp_q[i].at <= at) i++;
        exp_q.insert(i, e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        hi_acc += int'(pwm);
        if (edge_n % PERIOD == 0) begin
            frame_hi = hi_acc;
            hi_acc   = 0;
        end
        while (exp_q.size() > 0 && exp_q[0].at <= edge_n) begin
            e = exp_q.pop_front();
            case (e.sig)
                0:       chk(e.tag, 32'(pos), e.val);
                1:       chk(e.tag, 32'(moving), e.val);
                2:       chk(e.tag, 32'(pwm), e.val);
                default: chk(e.tag, 32'(frame_hi), e.val);
            endcase
        end
    endtask

    task automatic run_to(input int n, input logic [1:0] b);
        btn = b;
        while (edge_n < n) tick();
    endtask

    task automatic do_reset(input logic [1:0] b);
        @(negedge clk);
        #2 rst = 1'b1;
        btn = 2'b00;
        #1;
        chk("rst_pos", 32'(pos), 32'h80);
        chk("rst_pwm", 32'(pwm), 32'h0);
        chk("rst_moving", 32'(moving), 32'h0);
        chk("sb_leftover", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        btn    = b;
        rst    = 1'b0;
        edge_n = 0;
        hi_acc = 0;
    endtask

    initial begin
        // steady up-stepping from reset
        do_reset(2'b01);
        expect_at(1, 1, 1, "up_moving1");
        expect_at(1, 2, 1, "up_pwm1");
        expect_at(3, 0, 8'h80, "up_pos3");
        expect_at(4, 0, 8'h81, "up_pos4");
        expect_at(7, 0, 8'h81, "up_pos7");
        expect_at(8, 0, 8'h82, "up_pos8");
        expect_at(12, 0, 8'h83, "up_pos12");
        expect_at(13, 1, 0, "up_release_moving");
        expect_at(13, 0, 8'h83, "up_release_pos");
        run_to(12, 2'b01);
        run_to(14, 2'b00);

        // idle frame width, then a mid-frame position change
        do_reset(2'b00);
        expect_at(1000, 3, 356, "pwm_w_80");
        expect_at(1499, 0, 8'h80, "mid_pos_before");
        expect_at(1500, 0, 8'h81, "mid_pos_after");
        expect_at(1500, 1, 1, "mid_moving");
        expect_at(1501, 1, 0, "mid_idle");
        expect_at(2000, 3, 356, "pwm_w_cur_frame");
        expect_at(3000, 3, 358, "pwm_w_next_frame");
        run_to(1496, 2'b00);
        run_to(1500, 2'b01);
        run_to(3000, 2'b00);

        // upper saturation
        do_reset(2'b01);
        begin
            int n_up;
            n_up = (HI - 1 - 8'h80) * 4;
            expect_at(n_up, 0, 32'(HI - 1), "sat_hi_approach");
            expect_at(n_up + 1, 1, 0, "sat_hi_paused");
            expect_at(n_up + 4, 0, 32'(HI - 1), "sat_hi_pos3");
            expect_at(n_up + 5, 0, 32'(HI), "sat_hi_pos4");
            expect_at(n_up + 17, 0, 32'(HI), "sat_hi_pos16");
            expect_at(n_up + 17, 1, 1, "sat_hi_moving");
            expect_at(2000, 3, 32'(100 + HI * 2), "pwm_w_hi");
            run_to(n_up, 2'b01);
            run_to(n_up + 1, 2'b00);
            run_to(n_up + 17, 2'b01);
            run_to(2000, 2'b00);
        end

        // lower saturation
        do_reset(2'b10);
        begin
            int n_dn;
            n_dn = (8'h80 - LO) * 4;
            expect_at(n_dn - 1, 0, 32'(LO + 1), "sat_lo_approach");
            expect_at(n_dn, 0, 32'(LO), "sat_lo_reach");
            expect_at(n_dn + 8, 0, 32'(LO), "sat_lo_hold");
            expect_at(n_dn + 8, 1, 1, "sat_lo_moving");
            expect_at(2000, 3, 32'(100 + LO * 2), "pwm_w_lo");
            run_to(n_dn + 8, 2'b10);
            run_to(2000, 2'b00);
        end

        // hold command (11) aborts before any step
        do_reset(2'b01);
        expect_at(2, 1, 1, "hold_moving2");
        expect_at(3, 1, 0, "hold_moving3");
        expect_at(3, 0, 8'h80, "hold_pos3");
        expect_at(6, 0, 8'h80, "hold_pos6");
        run_to(2, 2'b01);
        run_to(6, 2'b11);

        // reversal restarts the step count
        do_reset(2'b01);
        expect_at(3, 1, 1, "rev_moving3");
        expect_at(6, 0, 8'h80, "rev_pos6");
        expect_at(7, 0, 8'h7F, "rev_pos7");
        run_to(2, 2'b01);
        run_to(8, 2'b10);

        // async reset mid-move while the pulse is high
        do_reset(2'b01);
        expect_at(2, 1, 1, "abort_moving_pre");
        expect_at(2, 2, 1, "abort_pwm_pre");
        expect_at(2, 0, 8'h80, "abort_pos_pre");
        run_to(2, 2'b01);
        do_reset(2'b01);
        expect_at(3, 0, 8'h80, "abort_pos3");
        expect_at(4, 0, 8'h81, "abort_pos4");
        run_to(4, 2'b01);

        chk("sb_final", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
